// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates conditional branches, issues a one-cycle
// BHT update and a fetch redirect on mispredict, then discards wrong-path slots.
//
// state  | meaning
// RUN    | branches are evaluated and may update the BHT / redirect fetch
// SQUASH | sq_cnt consumed slots are discarded after a redirect
module branch_resolve_unit #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 6,
    parameter int TAG_LSB    = 2,
    parameter int SQUASH_CYC = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    output logic             bht_upd_en,
    output logic [TAG_W-1:0] bht_upd_tag,
    output logic             bht_upd_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             squash_active,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int SQ_W = $clog2(SQUASH_CYC + 1);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [SQ_W-1:0] sq_cnt, sq_cnt_nxt;

    logic            slot_go;
    logic            legal;
    logic            accept;
    logic            taken;
    logic            mispred;
    logic [XLEN-1:0] target;

    assign slot_go = ex_valid && !ex_stall;
    assign legal   = (ex_funct3 != 3'b010) && (ex_funct3 != 3'b011);
    assign accept  = slot_go && ex_is_branch && legal && (state == RUN);

    always_comb begin
        taken = 1'b0;
        case (ex_funct3)
            3'b000:  taken = (ex_rs1 == ex_rs2);
            3'b001:  taken = (ex_rs1 != ex_rs2);
            3'b100:  taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  taken = (ex_rs1 <  ex_rs2);
            3'b111:  taken = (ex_rs1 >= ex_rs2);
            default: taken = 1'b0;
        endcase
    end

    // Address arithmetic wraps modulo 2^XLEN by construction.
    assign target  = ex_pc + (taken ? ex_imm : XLEN'(4));
    assign mispred = taken != ex_pred_taken;

    always_comb begin
        state_nxt  = state;
        sq_cnt_nxt = sq_cnt;
        case (state)
            RUN: begin
                if (accept && mispred) begin
                    state_nxt  = SQUASH;
                    sq_cnt_nxt = SQ_W'(SQUASH_CYC);
                end
            end
            SQUASH: begin
                if (slot_go) begin
                    sq_cnt_nxt = sq_cnt - SQ_W'(1);
                    if (sq_cnt == SQ_W'(1)) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt  = RUN;
                sq_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end

    assign squash_active = (state == SQUASH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bht_upd_en     <= 1'b0;
            bht_upd_tag    <= '0;
            bht_upd_taken  <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            bht_upd_en     <= 1'b0;
            redirect_valid <= 1'b0;
            if (accept) begin
                bht_upd_en    <= 1'b1;
                bht_upd_tag   <= ex_pc[TAG_LSB +: TAG_W];
                bht_upd_taken <= taken;
                if (br_count != '1) begin
                    br_count <= br_count + CNT_W'(1);
                end
                if (mispred) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                    if (mispred_count != '1) begin
                        mispred_count <= mispred_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution unit, directly upstream of the branch history table. It evaluates conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) and compares the outcome with the fetch-time prediction. It produces a registered one-cycle counter-update command for the BHT and a registered redirect for fetch on misprediction. After a redirect it suppresses wrong-path branches for a fixed squash window and keeps saturating branch and mispredict counters.

## Interface
Parameters:
- XLEN, 32, operand/PC width
- TAG_W, 6, BHT index width (matches BHT_PC_WIDTH)
- TAG_LSB, 2, lowest PC bit used for the BHT index
- SQUASH_CYC, 2, accepted EX slots discarded after a redirect (≥1)
- CNT_W, 32, width of performance counters

Ports:
- Reset is rst_n: asynchronous, active-low. Clock is clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX slot holds a valid instruction
- ex_stall  in  1  EX held this cycle; slot not consumed
- ex_is_branch  in  1  instruction is a conditional branch
- ex_funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- ex_rs1, ex_rs2  in  XLEN  forwarded operands
- ex_pc  in  XLEN  branch PC
- ex_imm  in  XLEN  sign-extended branch offset
- ex_pred_taken  in  1  prediction carried from fetch
- bht_upd_en  out  1  update strobe to BHT
- bht_upd_tag  out  TAG_W  BHT index = branch pc[TAG_LSB+TAG_W-1:TAG_LSB]
- bht_upd_taken  out  1  resolved direction
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  XLEN  corrected fetch PC
- squash_active  out  1  high while wrong-path branches are being discarded
- br_count, mispred_count  out  CNT_W  saturating counters

## Operation
- A slot is accepted when ex_valid=1, ex_stall=0, ex_is_branch=1 and the FSM is in RUN.
- funct3 codes 010/011 are illegal. An accepted slot carrying them is treated as not-taken, produces no update and no redirect, and is not counted.
- Condition: EQ/NE use bitwise compare. LT/GE use signed compare. LTU/GEU use unsigned compare.
- Target: taken → ex_pc+ex_imm. Not-taken → ex_pc+4. Both are computed mod 2^XLEN, so wrap-around is silent.
- Mispredict = resolved taken ≠ ex_pred_taken.
- Every accepted legal branch raises bht_upd_en for exactly one cycle, with bht_upd_tag and bht_upd_taken valid in that cycle. Otherwise bht_upd_en=0 and the other outputs hold their last values.
- On mispredict: redirect_valid=1 for one cycle with redirect_pc=target, and the FSM moves to SQUASH with sq_cnt=SQUASH_CYC.
- FSM RUN: accepts branches. Mispredict → SQUASH.
- FSM SQUASH: sq_cnt decrements on each cycle with ex_valid=1 and ex_stall=0, whether or not the slot is a branch. Branches in those slots are discarded: no update, no redirect, not counted. The FSM returns to RUN after the decrement that reaches 0.
- squash_active=1 exactly in SQUASH.
- br_count increments on each accepted legal branch. mispred_count increments on each mispredict. Both saturate at 2^CNT_W−1 and never wrap.
- ex_stall=1 freezes all evaluation and sq_cnt. Registered outputs still deassert their strobes.

## Timing
- Latency: branch accepted in cycle N → bht_upd_en, redirect_valid and the counter increments are visible in cycle N+1. All outputs are registered.
- Strobes last exactly one cycle, even if the same instruction persists without a stall.
- A branch accepted in the cycle the FSM returns to RUN is not possible. The first eligible slot is the cycle after sq_cnt reaches 0.
- Reset (asynchronous, any time, including mid-SQUASH): FSM=RUN, sq_cnt=0, all strobes 0, bht_upd_tag=0, bht_upd_taken=0, redirect_pc=0, counters=0. The first accept is possible in the first clock edge after release.
- The BHT update and redirect from the same branch appear in the same cycle. No ordering between them is required downstream.

## Test plan
- BEQ, rs1=rs2=5, pred=0, pc=0x100, imm=0x40 → next cycle: upd_en=1, tag=0x00, taken=1, redirect_valid=1, redirect_pc=0x140, mispred_count=1, squash_active=1.
- BLT rs1=0xFFFFFFFF, rs2=1, pred=1 → taken, no redirect, br_count+1. BLTU with the same operands, pred=1 → not-taken, redirect_pc=pc+4.
- SQUASH_CYC=2: mispredict followed by two valid branch slots (the second one stalled for 3 cycles) → both discarded, no strobes, squash_active stays high through the stall. A third branch is resolved normally.
- pc=0xFFFFFFF0, imm=0x20, BNE taken, pred=0 → redirect_pc=0x00000010. A branch with funct3=010 → no strobes, counters unchanged.
- Assert rst_n low during SQUASH → all outputs and counters 0 immediately. The branch after release is accepted.
- CNT_W=4: 20 mispredicting branches, each separated by a full squash window → both counters stick at 15.
